// File: rtl/inv_last_round_if.sv
// Handshake bundle for inv_last_round.
//   IN_VALID/IN_READY   : ciphertext block + round-10 key input handshake
//   IN_DATA / IN_KEY    : 128-bit block and key, byte 0 in [127:120]
//   OUT_VALID/OUT_READY : result output handshake
//   OUT_DATA            : 128-bit InvSubBytes(InvShiftRows(IN_DATA ^ IN_KEY))
// master = the side that supplies blocks and consumes results; slave = the round block.
interface inv_last_round_if;
  logic         IN_VALID;
  logic         IN_READY;
  logic [127:0] IN_DATA;
  logic [127:0] IN_KEY;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [127:0] OUT_DATA;

  modport master (
    output IN_VALID,
    output IN_DATA,
    output IN_KEY,
    output OUT_READY,
    input  IN_READY,
    input  OUT_VALID,
    input  OUT_DATA
  );

  modport slave (
    input  IN_VALID,
    input  IN_DATA,
    input  IN_KEY,
    input  OUT_READY,
    output IN_READY,
    output OUT_VALID,
    output OUT_DATA
  );
endinterface

// File: rtl/inv_last_round.sv
// Byte-serial first round of the AES-128 decryption datapath.
// Accepts one ciphertext block and the round-10 key, applies AddRoundKey, then
// InvShiftRows + InvSubBytes one byte per cycle through a single inverse S-box,
// and holds the result until the downstream core takes it.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : inv_last_round_if.slave (IN_* input handshake, OUT_* result handshake)
module inv_last_round (
  input logic            clk,
  input logic            rst,
  inv_last_round_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

  localparam logic [7:0] InvSbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  state_e       state_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [127:0] ark_q;
  logic [127:0] result_q;
  logic [3:0]   cnt_q;

  // Destination byte i = cnt_q = 4c+r. InvShiftRows pulls it from column (c-r) mod 4
  // of the same row; 2-bit subtraction wraps for free.
  logic [1:0] src_col;
  logic [3:0] src_idx;
  logic [6:0] rd_lsb;
  logic [6:0] wr_lsb;
  logic [7:0] sbox_in;
  logic [7:0] sbox_out;

  always_comb begin
    src_col  = cnt_q[3:2] - cnt_q[1:0];
    src_idx  = {src_col, cnt_q[1:0]};
    // Byte k lives at bits [127-8k -: 8], i.e. LSB at 8*(15-k) = {~k, 3'b000}.
    rd_lsb   = {~src_idx, 3'b000};
    wr_lsb   = {~cnt_q, 3'b000};
    sbox_in  = ark_q[rd_lsb +: 8];
    sbox_out = InvSbox[sbox_in];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ark_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.IN_VALID) begin
            ark_q      <= bus.IN_DATA ^ bus.IN_KEY;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StSub;
          end
        end
        StSub: begin
          result_q[wr_lsb +: 8] <= sbox_out;
          cnt_q                 <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.OUT_READY) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT_DATA  = result_q;

endmodule
